// File: rtl/load_controller.sv
// load_controller: streams data-memory rows through the switch into core registers, then pulses coreStart
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   start, storeBusy       load request (level, must be held) and store-in-progress gate
//   memRead, swEnable      memory read strobe and switch enable
//   memRdtoReg             register write strobe for the row on the switch
//   rowaddr, rowaddrtoSw   binary row address and its one-hot switch select
//   coreStart              one-cycle start pulse to every core
//   busy, loadDone         pass in progress / last pass completed
module load_controller #(
  parameter int NUM_ROWS  = 16,
  parameter int ADDR_W    = 4,
  parameter int NUM_CORES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   storeBusy,
  output logic                   memRead,
  output logic                   swEnable,
  output logic                   memRdtoReg,
  output logic [ADDR_W-1:0]      rowaddr,
  output logic [2**ADDR_W-1:0]   rowaddrtoSw,
  output logic [NUM_CORES-1:0]   coreStart,
  output logic                   busy,
  output logic                   loadDone
);
  localparam int SW_W = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(NUM_ROWS - 1);
  typedef enum logic [2:0] {IDLE, READ, WRITE, GO, DONE} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] row_q, row_d;
  logic in_rows;
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    case (state_q)
      IDLE, DONE: if (start && !storeBusy) begin
        state_d = READ;
        row_d   = '0;
      end
      READ:  state_d = WRITE;
      WRITE: if (row_q == LAST_ROW) state_d = GO;
             else begin
               state_d = READ;
               row_d   = row_q + 1'b1;
             end
      GO:      state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
    end
  end
  // Moore decode straight off the state flops: every output is valid in the cycle its state is entered
  assign in_rows     = (state_q == READ) || (state_q == WRITE);
  assign memRead     = state_q == READ;
  assign memRdtoReg  = state_q == WRITE;
  assign swEnable    = in_rows;
  assign rowaddr     = in_rows ? row_q : '0;
  assign rowaddrtoSw = in_rows ? (SW_W'(1) << row_q) : '0;
  assign coreStart   = {NUM_CORES{state_q == GO}};
  assign busy        = in_rows || (state_q == GO);
  assign loadDone    = state_q == DONE;
endmodule

// File: tb/tb_load_controller.sv
// tb_load_controller: directed checks of the load pass, store gating, mid-pass restart and async abort
module tb_load_controller;
  localparam int NR = 16;
  localparam int PASS_CYCLES = 2*NR + 2;
  logic clk, rst_n, start, storeBusy;
  logic memRead, swEnable, memRdtoReg, busy, loadDone;
  logic [3:0] rowaddr, coreStart;
  logic [15:0] rowaddrtoSw;
  int vectors = 0;
  int miscompares = 0;

  load_controller dut (
    .clk(clk), .rst_n(rst_n), .start(start), .storeBusy(storeBusy),
    .memRead(memRead), .swEnable(swEnable), .memRdtoReg(memRdtoReg),
    .rowaddr(rowaddr), .rowaddrtoSw(rowaddrtoSw), .coreStart(coreStart),
    .busy(busy), .loadDone(loadDone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag, input logic exp_done);
    check({tag, "_memRead"}, memRead, 0);
    check({tag, "_swEnable"}, swEnable, 0);
    check({tag, "_memRdtoReg"}, memRdtoReg, 0);
    check({tag, "_rowaddr"}, rowaddr, 0);
    check({tag, "_rowaddrtoSw"}, rowaddrtoSw, 0);
    check({tag, "_coreStart"}, coreStart, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_loadDone"}, loadDone, exp_done);
  endtask

  // Called one cycle after the accepting edge; walks the whole pass up to the first DONE cycle.
  // poke_c > 0 re-asserts start for one cycle at that pass cycle.
  task automatic run_pass(input int poke_c);
    int reads = 0, writes = 0, pulses = 0;
    for (int c = 1; c <= PASS_CYCLES; c++) begin
      logic [3:0] row;
      row = 4'((c - 1) / 2);
      if (c <= 2*NR) begin
        check("rd", memRead, (c % 2) == 1);
        check("wr", memRdtoReg, (c % 2) == 0);
        check("sw", swEnable, 1);
        check("row", rowaddr, row);
        check("onehot", rowaddrtoSw, 32'(16'h1 << row));
        check("core", coreStart, 0);
        check("busy", busy, 1);
        check("done", loadDone, 0);
      end else if (c == 2*NR + 1) begin
        check("go_core", coreStart, 4'hf);
        check("go_busy", busy, 1);
        check("go_sw", swEnable, 0);
        check("go_row", rowaddr, 0);
        check("go_done", loadDone, 0);
      end else check_idle("fin", 1'b1);
      reads  += int'(memRead);
      writes += int'(memRdtoReg);
      pulses += int'(coreStart == 4'hf);
      if (c == poke_c) start = 1'b1;
      if (c == poke_c + 1) start = 1'b0;
      if (c < PASS_CYCLES) tick();
    end
    start = 1'b0;
    check("reads", reads, NR);
    check("writes", writes, NR);
    check("pulses", pulses, 1);
  endtask

  always @(negedge clk) begin
    check("inv_rd_wr", memRead & memRdtoReg, 0);
    check("inv_sw", rowaddrtoSw, swEnable ? 32'(16'h1 << rowaddr) : 32'h0);
  end

  initial begin
    rst_n = 1'b1;
    start = 1'b0;
    storeBusy = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_idle("rst", 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check_idle("post_rst", 1'b0);

    // single-cycle start, full pass
    start = 1'b1;
    tick();
    start = 1'b0;
    run_pass(0);

    // held start blocked by storeBusy, accepted when it drops
    start = 1'b1;
    storeBusy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_idle("blocked", 1'b1);
    end
    storeBusy = 1'b0;
    tick();
    start = 1'b0;
    check("acc_onehot", rowaddrtoSw, 16'h0001);
    run_pass(0);

    // start re-pulsed during row 7 WRITE is ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    run_pass(16);

    // asynchronous abort during row 9
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 19; c++) tick();
    check("pre_abort_row", rowaddr, 9);
    check("pre_abort_rd", memRead, 1);
    #2 rst_n = 1'b0;
    #1 check_idle("abort", 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle("abort_hold", 1'b0);
    end
    rst_n = 1'b1;
    tick();
    check_idle("abort_rel", 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    run_pass(0);

    // back-to-back: accept straight out of DONE
    start = 1'b1;
    tick();
    start = 1'b0;
    check("b2b_done_drop", loadDone, 0);
    run_pass(0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
